vga_pixel_pipe: RTL and testbench

VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

---
 rtl/vga_pixel_pipe_if.sv | 22 ++
 rtl/vga_pixel_pipe.sv | 177 +++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer write port bundle for vga_pixel_pipe.
// Host drives valid/addr/data; the pipe answers with ready.
interface vga_pixel_pipe_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipe: scaled framebuffer fetch, palette lookup, sync align.
// Host writes and clears share the single RAM port during blanking only.
module vga_pixel_pipe #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic            vgaclk,
  input  logic            reset_n,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic            hsync,
  input  logic            vsync,
  input  logic            blank_b,
  vga_pixel_pipe_if.slave wr,
  input  logic            clr_start,
  input  logic [1:0]      clr_color,
  output logic            clr_busy,
  input  logic            pal_we,
  input  logic [1:0]      pal_idx,
  input  logic [11:0]     pal_data,
  output logic [3:0]      r,
  output logic [3:0]      g,
  output logic [3:0]      b,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic            blank_b_out
);

  localparam int unsigned NPIX = FB_W * FB_H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam logic [14:0] LAST = 15'(NPIX - 1);
  localparam logic [14:0] W_FB = 15'(FB_W);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_cnt;
  logic [14:0] w_cnt_nxt;
  logic [1:0]  r_ccol;
  logic [1:0]  w_ccol_nxt;
  logic        w_clr_we;

  logic [14:0] w_row;
  logic [14:0] w_col;
  logic [14:0] w_addr0;

  logic        w_host_we;
  logic        w_we;
  logic [1:0]  w_wdata;
  logic [14:0] w_ram_addr;

  logic [1:0]  r_mem [NPIX];
  logic [1:0]  r_rd1;
  logic [1:0]  r_rd2;

  logic [2:0]  r_hs;
  logic [2:0]  r_vs;
  logic [2:0]  r_bl;
  logic [11:0] r_rgb;
  logic [11:0] r_pal [4];

  // Stage 0: row*FB_W + col built from shifted copies of the row
  always_comb begin
    w_row   = 15'(y >> SCALE_SHIFT);
    w_col   = 15'(x >> SCALE_SHIFT);
    w_addr0 = w_col;
    for (int i = 0; i < 15; i++) begin
      if (W_FB[i]) begin
        w_addr0 = w_addr0 + (w_row << i);
      end
    end
  end

  assign wr.wr_ready = ~blank_b & (r_state == S_IDLE) & ~clr_start;
  assign clr_busy    = (r_state == S_CLEAR);

  // Clear FSM next state; writes only land in blanked cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ccol_nxt  = r_ccol;
    w_clr_we    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_ccol_nxt  = clr_color;
        end
      end
      S_CLEAR: begin
        if (!blank_b) begin
          w_clr_we = 1'b1;
          if (r_cnt == LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 15'd1;
          end
        end
      end
    endcase
  end

  // Clear FSM state, counter and latched colour
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ccol  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ccol  <= w_ccol_nxt;
    end
  end

  // Port mux: display owns the RAM while visible, writers otherwise
  always_comb begin
    w_host_we  = wr.wr_valid & wr.wr_ready & (wr.wr_addr <= LAST);
    w_we       = w_clr_we | w_host_we;
    w_wdata    = w_clr_we ? r_ccol : wr.wr_data;
    w_ram_addr = w_addr0;
    if (!blank_b) begin
      w_ram_addr = w_clr_we ? r_cnt : wr.wr_addr;
    end
  end

  // Single-port framebuffer with registered read (stage 1)
  always_ff @(posedge vgaclk) begin
    if (w_we) begin
      r_mem[w_ram_addr[AW-1:0]] <= w_wdata;
    end
    r_rd1 <= r_mem[w_ram_addr[AW-1:0]];
  end

  // Stages 1-3: timing delay line, read hold, gated palette output
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs  <= 3'b111;
      r_vs  <= 3'b111;
      r_bl  <= 3'b000;
      r_rd2 <= '0;
      r_rgb <= '0;
    end else begin
      r_hs  <= {r_hs[1:0], hsync};
      r_vs  <= {r_vs[1:0], vsync};
      r_bl  <= {r_bl[1:0], blank_b};
      r_rd2 <= r_rd1;
      r_rgb <= r_bl[1] ? r_pal[r_rd2] : 12'h000;
    end
  end

  // Palette entries, writable at any time
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      r_pal[0] <= 12'h000;
      r_pal[1] <= 12'hF00;
      r_pal[2] <= 12'h0F0;
      r_pal[3] <= 12'hFFF;
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_data;
    end
  end

  assign r           = r_rgb[11:8];
  assign g           = r_rgb[7:4];
  assign b           = r_rgb[3:0];
  assign hsync_out   = r_hs[2];
  assign vsync_out   = r_vs[2];
  assign blank_b_out = r_bl[2];

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomised bench for vga_pixel_pipe against a behavioural model.
// Small framebuffer and short frames keep the run compact.
module tb_vga_pixel_pipe;

  localparam int FBW = 20;
  localparam int FBH = 8;
  localparam int SS  = 2;
  localparam int NP  = FBW * FBH;
  localparam int HV  = FBW << SS;
  localparam int VV  = FBH << SS;
  localparam int HT  = 100;
  localparam int HS0 = 84;
  localparam int HS1 = 92;
  localparam int VT  = 38;
  localparam int VS0 = 33;
  localparam int VS1 = 35;
  localparam int FR  = HT * VT;

  logic        vgaclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        blank_b = 1'b0;
  logic        clr_start = 1'b0;
  logic [1:0]  clr_color = '0;
  logic        clr_busy;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = '0;
  logic [11:0] pal_data = '0;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_b_out;

  vga_pixel_pipe_if wr ();

  vga_pixel_pipe #(
    .FB_W(FBW),
    .FB_H(FBH),
    .SCALE_SHIFT(SS)
  ) dut (
    .vgaclk(vgaclk),
    .reset_n(reset_n),
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .blank_b(blank_b),
    .wr(wr),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy(clr_busy),
    .pal_we(pal_we),
    .pal_idx(pal_idx),
    .pal_data(pal_data),
    .r(r),
    .g(g),
    .b(b),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .blank_b_out(blank_b_out)
  );

  always #5 vgaclk = ~vgaclk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string n, logic [11:0] act, logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit         hs;
    bit         vs;
    bit         bl;
    bit         kn;
    logic [1:0] v;
    int         px;
    int         py;
  } tok_t;

  function automatic tok_t idle_tok();
    tok_t t;
    t.hs = 1'b1;
    t.vs = 1'b1;
    t.bl = 1'b0;
    t.kn = 1'b1;
    t.v  = '0;
    t.px = -1;
    t.py = -1;
    return t;
  endfunction

  logic [1:0]  fb  [NP];
  bit          fbk [NP];
  logic [11:0] pal [4];
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [1:0]  m_col = '0;
  tok_t        t1;
  tok_t        t2;
  tok_t        texp;
  logic [11:0] e_rgb = '0;
  bit          e_rgbk = 1'b1;
  logic [11:0] seen [VV][HV];

  // Model: RAM sampled when the pixel enters, palette two edges later
  always @(posedge vgaclk) begin
    if (!reset_n) begin
      m_on   = 1'b1;
      m_busy = 1'b0;
      m_cnt  = 0;
      pal[0] = 12'h000;
      pal[1] = 12'hF00;
      pal[2] = 12'h0F0;
      pal[3] = 12'hFFF;
      t1     = idle_tok();
      t2     = idle_tok();
      texp   = idle_tok();
      e_rgb  = '0;
      e_rgbk = 1'b1;
    end else begin
      tok_t nt;
      int   a;
      a     = (int'(y) >> SS) * FBW + (int'(x) >> SS);
      nt.hs = hsync;
      nt.vs = vsync;
      nt.bl = blank_b;
      nt.px = int'(x);
      nt.py = int'(y);
      nt.kn = 1'b1;
      nt.v  = '0;
      if (blank_b && a < NP) begin
        nt.kn = fbk[a];
        nt.v  = fb[a];
      end
      texp   = t2;
      e_rgbk = !t2.bl || t2.kn;
      e_rgb  = t2.bl ? pal[t2.v] : 12'h000;
      if (m_busy) begin
        if (!blank_b) begin
          fb[m_cnt]  = m_col;
          fbk[m_cnt] = 1'b1;
          if (m_cnt == NP - 1) m_busy = 1'b0;
          else m_cnt++;
        end
      end else if (clr_start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_col  = clr_color;
      end else if (!blank_b && wr.wr_valid && int'(wr.wr_addr) < NP) begin
        fb[wr.wr_addr]  = wr.wr_data;
        fbk[wr.wr_addr] = 1'b1;
      end
      if (pal_we) pal[pal_idx] = pal_data;
      t2 = t1;
      t1 = nt;
    end
  end

  // Compare: registered outputs at negedge, wr_ready once inputs settle
  always @(negedge vgaclk) begin
    if (m_on) begin
      chk("hsync_out", 12'(hsync_out), 12'(texp.hs));
      chk("vsync_out", 12'(vsync_out), 12'(texp.vs));
      chk("blank_b_out", 12'(blank_b_out), 12'(texp.bl));
      chk("clr_busy", 12'(clr_busy), 12'(m_busy));
      if (e_rgbk) chk("rgb", {r, g, b}, e_rgb);
      if (texp.bl && texp.px >= 0 && texp.px < HV && texp.py >= 0 && texp.py < VV)
        seen[texp.py][texp.px] = {r, g, b};
      #3;
      if (reset_n)
        chk("wr_ready", 12'(wr.wr_ready), 12'(!blank_b && !m_busy && !clr_start));
    end
  end

  int          hc = 0;
  int          vc = 0;
  bit          rnd_wr = 1'b0;
  bit          rnd_pal = 1'b0;
  bit          d_wr = 1'b0;
  logic [14:0] d_addr = '0;
  logic [1:0]  d_data = '0;
  bit          d_clr = 1'b0;
  logic [1:0]  d_ccol = '0;
  bit          d_pal = 1'b0;
  logic [1:0]  d_pidx = '0;
  logic [11:0] d_pdat = '0;

  task automatic tick();
    @(negedge vgaclk);
    #1;
    x           = 10'(hc);
    y           = 10'(vc);
    blank_b     = (hc < HV) && (vc < VV);
    hsync       = !(hc >= HS0 && hc < HS1);
    vsync       = !(vc >= VS0 && vc < VS1);
    wr.wr_valid = rnd_wr && ($urandom % 3 == 0);
    wr.wr_addr  = 15'($urandom % (NP + 20));
    wr.wr_data  = 2'($urandom);
    clr_start   = rnd_wr && ($urandom % 2500 == 0);
    clr_color   = 2'($urandom);
    pal_we      = rnd_pal && ($urandom % 150 == 0);
    pal_idx     = 2'($urandom);
    pal_data    = 12'($urandom);
    if (reset_n && d_clr && !blank_b && !clr_busy) begin
      clr_start = 1'b1;
      clr_color = d_ccol;
      d_clr     = 1'b0;
    end
    if (reset_n && d_wr && !blank_b && !clr_busy && !clr_start) begin
      wr.wr_valid = 1'b1;
      wr.wr_addr  = d_addr;
      wr.wr_data  = d_data;
      d_wr        = 1'b0;
    end
    if (reset_n && d_pal && blank_b && hc == HV / 2) begin
      pal_we   = 1'b1;
      pal_idx  = d_pidx;
      pal_data = d_pdat;
      d_pal    = 1'b0;
    end
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end
  endtask

  task automatic frames(int n);
    repeat (n * FR) tick();
  endtask

  task automatic wait_clear(string n);
    for (int i = 0; i < 3 * FR && (d_clr || clr_busy); i++) tick();
    chk(n, 12'(clr_busy || d_clr), 12'h000);
  endtask

  task automatic wait_wr(string n);
    for (int i = 0; i < 2 * FR && d_wr; i++) tick();
    chk(n, 12'(d_wr), 12'h000);
  endtask

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_addr  = '0;
    wr.wr_data  = '0;
    reset_n     = 1'b0;
    repeat (4) tick();
    chk("rst_rgb", {r, g, b}, 12'h000);
    chk("rst_hs", 12'(hsync_out), 12'h001);
    chk("rst_vs", 12'(vsync_out), 12'h001);
    chk("rst_blank", 12'(blank_b_out), 12'h000);
    chk("rst_busy", 12'(clr_busy), 12'h000);
    reset_n = 1'b1;

    d_ccol = 2'd2;
    d_clr  = 1'b1;
    wait_clear("clr_done_a");
    frames(2);
    chk("clr_px00", seen[0][0], 12'h0F0);
    chk("clr_pxlast", seen[VV-1][HV-1], 12'h0F0);

    d_addr = 15'(FBW + 1);
    d_data = 2'd3;
    d_wr   = 1'b1;
    wait_wr("wr_sent");
    frames(2);
    chk("wr_px44", seen[4][4], 12'hFFF);
    chk("wr_px77", seen[7][7], 12'hFFF);
    chk("wr_px55", seen[5][5], 12'hFFF);
    chk("nb_px35", seen[3][5], 12'h0F0);
    chk("nb_px85", seen[8][5], 12'h0F0);
    chk("nb_px58", seen[5][8], 12'h0F0);

    d_addr = 15'(NP);
    d_data = 2'd0;
    d_wr   = 1'b1;
    wait_wr("oor_sent");
    d_addr = 15'h7FFF;
    d_wr   = 1'b1;
    wait_wr("oor2_sent");
    frames(1);
    chk("oor_px00", seen[0][0], 12'h0F0);
    chk("oor_pxlast", seen[VV-1][HV-1], 12'h0F0);

    d_pidx = 2'd2;
    d_pdat = 12'h00F;
    d_pal  = 1'b1;
    frames(2);
    chk("pal_px", seen[20][30], 12'h00F);
    chk("pal_px3", seen[5][5], 12'hFFF);

    rnd_wr  = 1'b1;
    rnd_pal = 1'b1;
    frames(3);
    rnd_wr  = 1'b0;
    rnd_pal = 1'b0;
    wait_clear("rnd_idle");

    d_ccol = 2'd3;
    d_clr  = 1'b1;
    for (int i = 0; i < 2 * FR && !clr_busy; i++) tick();
    chk("clr_b_start", 12'(clr_busy), 12'h001);
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    chk("busy_async", 12'(clr_busy), 12'h000);
    repeat (2) tick();
    reset_n = 1'b1;
    d_ccol  = 2'd1;
    d_clr   = 1'b1;
    wait_clear("clr_done_e");
    frames(2);
    chk("rst_clr_px00", seen[0][0], 12'hF00);
    chk("rst_clr_pxlast", seen[VV-1][HV-1], 12'hF00);
    chk("rst_clr_px55", seen[5][5], 12'hF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
